apb_sram_arbiter: RTL and testbench

//  Two-requester APB master that shares the single APB SRAM slave between two local clients.

---
 rtl/apb_ctrl_pkg.sv | 13 +
 rtl/apb_sram_arbiter_rr_arbiter_2.sv | 33 +++
 rtl/apb_sram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_apb_sram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared definitions for the APB master side: FSM state encoding and fixed
// protection attributes driven on every transfer.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb_sram_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter. The pointer remembers the last requester whose
// transfer completed; on a tie the other requester wins.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd_en,
  input  logic       upd_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_q, last_d;

  // Reset to "req1 was last" so req0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = upd_en ? upd_id : last_q;
  end

  always_comb begin
    gnt_valid = |req;
    gnt_id    = (req == 2'b11) ? ~last_q : req[1];
  end

endmodule

// File: rtl/apb_sram_arbiter.sv
// Two-client APB master: round-robin grants one command at a time onto the
// shared SRAM slave and returns registered responses to the owning client.
module apb_sram_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    req0_valid,
  input  logic                    req0_write,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  output logic                    req0_ready,
  output logic                    rsp0_valid,
  output logic [DATA_WIDTH-1:0]   rsp0_rdata,
  output logic                    rsp0_err,
  input  logic                    req1_valid,
  input  logic                    req1_write,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  output logic                    req1_ready,
  output logic                    rsp1_valid,
  output logic [DATA_WIDTH-1:0]   rsp1_rdata,
  output logic                    rsp1_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  apb_state_e            state_q, state_d;
  logic                  gnt_id_q, gnt_id_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]         tmo_q, tmo_d;
  logic                  arb_valid, arb_id;
  logic                  xfer_done, xfer_tmo;

  assign xfer_done = (state_q == ST_ACCESS) && (PREADY || (tmo_q == TMO_LAST));
  assign xfer_tmo  = (state_q == ST_ACCESS) && !PREADY && (tmo_q == TMO_LAST);

  rr_arbiter_2 u_arb (
    .clk       (PCLK),
    .rst       (PRESET),
    .req       ({req1_valid, req0_valid}),
    .upd_en    (xfer_done),
    .upd_id    (gnt_id_q),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      gnt_id_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next state plus command latch; the command is captured only on a grant.
  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tmo_d    = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d  = ST_SETUP;
          gnt_id_d = arb_id;
          write_d  = arb_id ? req1_write : req0_write;
          addr_d   = arb_id ? req1_addr  : req0_addr;
          wdata_d  = arb_id ? req1_wdata : req0_wdata;
          tmo_d    = '0;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (xfer_done) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is gated by reset so every output reads 0 while PRESET is high.
  always_comb begin
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PWRITE     = 1'b0;
    PADDR      = '0;
    PWDATA     = '0;
    PSTRB      = '0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid && !PRESET) begin
          req0_ready = ~arb_id;
          req1_ready = arb_id;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (state_q == ST_ACCESS);
        PWRITE  = write_q;
        PADDR   = addr_q;
        PWDATA  = wdata_q;
        PSTRB   = write_q ? '1 : '0;
      end
      default: ;
    endcase
  end

  assign PPROT = PPROT_DEFAULT;

  logic [1:0]                 rsp_valid;
  logic [1:0]                 rsp_err;
  logic [1:0][DATA_WIDTH-1:0] rsp_rdata;

  // Per-client response registers; rdata/err hold until that client's next response.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mine;

    assign mine = xfer_done && (gnt_id_q == 1'(gi));

    always_comb begin
      valid_d = mine;
      err_d   = err_q;
      rdata_d = rdata_q;
      if (mine) begin
        err_d   = xfer_tmo | (PREADY & PSLVERR);
        rdata_d = (PREADY && !write_q) ? PRDATA : '0;
      end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        valid_q <= valid_d;
        err_q   <= err_d;
        rdata_q <= rdata_d;
      end
    end

    assign rsp_valid[gi] = valid_q;
    assign rsp_err[gi]   = err_q;
    assign rsp_rdata[gi] = rdata_q;
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_err   = rsp_err[0];
  assign rsp1_err   = rsp_err[1];
  assign rsp0_rdata = rsp_rdata[0];
  assign rsp1_rdata = rsp_rdata[1];

endmodule

// File: tb/tb_apb_sram_arbiter.sv
// Bench for apb_sram_arbiter: APB SRAM slave model, memory scoreboard,
// directed vector table, timeout/abort/alternation sequences and random traffic.
module tb_apb_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req0_valid = 1'b0, req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [DW/8-1:0] PSTRB;
  logic [2:0]    PPROT;

  apb_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(clk), .PRESET(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- APB SRAM slave model ----------------
  bit stall = 1'b0, rand_waits = 1'b0, slave_init = 1'b1;
  logic [31:0] smem [0:255];
  int wcnt = 0, wtgt = 0;

  // Addresses 0xF00-0xFFF answer with PSLVERR.
  function automatic bit err_addr(input logic [31:0] a);
    return a[11:8] == 4'hF;
  endfunction

  always_comb begin
    PREADY  = PSEL && PENABLE && !stall && (wcnt >= wtgt);
    PSLVERR = PREADY && err_addr(PADDR);
    PRDATA  = (PREADY && !PWRITE && !err_addr(PADDR)) ? smem[PADDR[9:2]] : '0;
  end

  always @(posedge clk) begin
    if (slave_init) begin
      for (int i = 0; i < 256; i++) smem[i] <= '0;
      smem[4] <= 32'hA5;
    end else if (PSEL && !PENABLE) begin
      wcnt <= 0;
      wtgt <= rand_waits ? int'($urandom_range(0, 3)) : 0;
    end else if (PSEL && PENABLE) begin
      wcnt <= wcnt + 1;
      if (PREADY && PWRITE && !PSLVERR) smem[PADDR[9:2]] <= PWDATA;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  logic [31:0] ref_mem [0:255];
  int prev_win = 1;

  // Transfers are serialised, so acceptance order is execution order.
  task automatic accept(input int k, input bit both, input bit w, input logic [31:0] a,
                        input logic [31:0] d);
    exp_t e;
    if (both) check($sformatf("rr_winner_req%0d", k), k, 1 - prev_win);
    prev_win = k;
    e.err   = stall || err_addr(a);
    e.rdata = '0;
    if (!e.err && w)  ref_mem[a[9:2]] = d;
    if (!e.err && !w) e.rdata = ref_mem[a[9:2]];
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic retire(input int k, input logic [31:0] rd, input logic er);
    exp_t e;
    int depth;
    depth = (k == 0) ? exp_q0.size() : exp_q1.size();
    check($sformatf("sb_rsp%0d_expected", k), depth > 0, 1);
    if (depth > 0) begin
      if (k == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      check($sformatf("sb_rsp%0d_rdata", k), rd, e.rdata);
      check($sformatf("sb_rsp%0d_err", k), er, e.err);
    end
  endtask

  always @(negedge clk) begin
    if (slave_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      ref_mem[4] = 32'hA5;
    end
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      prev_win = 1;
    end else if (!slave_init) begin
      if (req0_ready && req1_ready) check("single_ready", 1'b1, 1'b0);
      if (req0_ready) begin
        check("ready0_has_valid", req0_valid, 1);
        accept(0, req1_valid, req0_write, req0_addr, req0_wdata);
      end
      if (req1_ready) begin
        check("ready1_has_valid", req1_valid, 1);
        accept(1, req0_valid, req1_write, req1_addr, req1_wdata);
      end
      if (rsp0_valid) retire(0, rsp0_rdata, rsp0_err);
      if (rsp1_valid) retire(1, rsp1_rdata, rsp1_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input int who, input bit v, input bit w, input logic [31:0] a,
                           input logic [31:0] d);
    if (who == 0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  function automatic logic ready_of(input int who);
    return (who == 0) ? req0_ready : req1_ready;
  endfunction

  // One transfer against an idle arbiter and zero-wait slave; checks phase timing.
  task automatic run_xfer(input int who, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output bit ok);
    int n;
    bit got;
    rd = '0; er = 1'b0; ok = 1'b0; n = 0;
    @(posedge clk); #1;
    drive_req(who, 1'b1, w, a, d);
    do begin @(negedge clk); n++; end while (!ready_of(who) && n < 20);
    got = ready_of(who);
    check($sformatf("x_req%0d_ready_cycle", who), n, 1);
    @(posedge clk); #1;
    drive_req(who, 1'b0, 1'b0, '0, '0);
    if (!got) return;
    @(negedge clk);
    check("setup_phase", {PSEL, PENABLE, PWRITE}, {2'b10, w});
    check("setup_paddr", PADDR, a);
    check("setup_pstrb", PSTRB, w ? 4'hF : 4'h0);
    if (w) check("setup_pwdata", PWDATA, d);
    @(negedge clk);
    check("access_phase", {PSEL, PENABLE, PWRITE}, {2'b11, w});
    check("access_paddr", PADDR, a);
    @(negedge clk);
    check($sformatf("rsp%0d_valid_t3", who), (who == 0) ? rsp0_valid : rsp1_valid, 1);
    check("idle_psel", {PSEL, PENABLE}, 2'b00);
    rd = (who == 0) ? rsp0_rdata : rsp1_rdata;
    er = (who == 0) ? rsp0_err : rsp1_err;
    ok = 1'b1;
  endtask

  task automatic rand_driver(input int who, input int count);
    for (int i = 0; i < count; i++) begin
      logic [31:0] a, d;
      bit w, got;
      int n;
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'hF00 + 32'($urandom_range(0, 63) * 4);
      else                           a = 32'($urandom_range(0, 255) * 4);
      d = $urandom;
      @(posedge clk); #1;
      drive_req(who, 1'b1, w, a, d);
      n = 0;
      do begin @(negedge clk); n++; end while (!ready_of(who) && n < 60);
      got = ready_of(who);
      check($sformatf("rand_req%0d_accepted", who), got, 1);
      @(posedge clk); #1;
      drive_req(who, 1'b0, 1'b0, '0, '0);
      if (!got) break;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  typedef struct {
    int          who;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt [8];
    logic [31:0] rd;
    logic er;
    bit ok, got;
    int n, acc;
    int win_id[$];
    int win_cyc[$];

    vt[0] = '{0, 1'b0, 32'h010, 32'h0,        32'h0000_00A5, 1'b0};
    vt[1] = '{0, 1'b1, 32'h020, 32'h5A,       32'h0,         1'b0};
    vt[2] = '{1, 1'b0, 32'h020, 32'h0,        32'h0000_005A, 1'b0};
    vt[3] = '{1, 1'b0, 32'hF04, 32'h0,        32'h0,         1'b1};
    vt[4] = '{0, 1'b1, 32'hF08, 32'h1234,     32'h0,         1'b1};
    vt[5] = '{1, 1'b1, 32'h024, 32'hDEADBEEF, 32'h0,         1'b0};
    vt[6] = '{0, 1'b0, 32'h024, 32'h0,        32'hDEADBEEF,  1'b0};
    vt[7] = '{1, 1'b0, 32'h010, 32'h0,        32'h0000_00A5, 1'b0};

    // Reset with both requests asserted: everything must read 0.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_apb_ctrl", {PSEL, PENABLE, PWRITE, PSTRB, PPROT}, 0);
    check("rst_paddr_pwdata", {PADDR, PWDATA}, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_rsp_flags", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
    check("rst_rsp_rdata", {rsp0_rdata, rsp1_rdata}, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    slave_init = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_xfer(vt[i].who, vt[i].write, vt[i].addr, vt[i].wdata, rd, er, ok);
      if (ok) begin
        check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
        check($sformatf("vec%0d_err", i), er, vt[i].exp_err);
      end
    end
    check("rsp0_rdata_hold", rsp0_rdata, 32'hDEADBEEF);

    // Stalled slave: 16 ACCESS cycles, then a forced error response.
    stall = 1'b1;
    @(posedge clk); #1;
    drive_req(1, 1'b1, 1'b0, 32'h40, '0);
    n = 0;
    do begin @(negedge clk); n++; end while (!req1_ready && n < 20);
    got = req1_ready;
    check("tmo_ready", got, 1);
    @(posedge clk); #1;
    drive_req(1, 1'b0, 1'b0, '0, '0);
    acc = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (PSEL && PENABLE) acc++;
    end while (!(acc > 0 && !PSEL) && n < 60);
    check("tmo_access_cycles", acc, 16);
    check("tmo_rsp_valid", rsp1_valid, 1);
    check("tmo_err", rsp1_err, 1);
    check("tmo_rdata", rsp1_rdata, 0);

    // Reset asserted mid-ACCESS: bus drops at once, no response afterwards.
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b0, 32'h44, '0);
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
    check("abort_ready", req0_ready, 1);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_access", {PSEL, PENABLE}, 2'b11);
    #2;
    rst = 1'b1;
    req0_valid = 1'b1;
    #1;
    check("abort_apb_drop", {PSEL, PENABLE}, 0);
    check("abort_no_ready", {req0_ready, req1_ready}, 0);
    check("abort_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Both held valid: grants alternate 0,1,0,1 every 3 cycles.
    drive_req(0, 1'b1, 1'b0, 32'h10, '0);
    drive_req(1, 1'b1, 1'b0, 32'h20, '0);
    n = 0;
    while (win_id.size() < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (req0_ready) begin win_id.push_back(0); win_cyc.push_back(n); end
      if (req1_ready) begin win_id.push_back(1); win_cyc.push_back(n); end
    end
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    check("alt_grant_count", win_id.size(), 4);
    for (int i = 0; i < win_id.size(); i++) begin
      check($sformatf("alt_winner_%0d", i), win_id[i], i % 2);
      if (i > 0) check($sformatf("alt_gap_%0d", i), win_cyc[i] - win_cyc[i-1], 3);
    end
    repeat (8) @(negedge clk);

    // Random traffic from both clients with random wait states.
    rand_waits = 1'b1;
    fork
      rand_driver(0, 40);
      rand_driver(1, 40);
    join
    repeat (20) @(negedge clk);
    rand_waits = 1'b0;
    check("sb_drain0", exp_q0.size(), 0);
    check("sb_drain1", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
